// File: rtl/mm_result_unloader.sv
// Result unloader for the 3x3 matrix-multiply MAC array: snapshots the nine
// accumulators on an unload edge and streams the valid rows x cols region row-major.
module mm_result_unloader #(
  parameter int RES_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               unload_res,
  input  logic [1:0]         row_w,
  input  logic [1:0]         col_x,
  input  logic [9*RES_W-1:0] mac_res,
  output logic [RES_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  logic [1:0]       state;
  logic             prev;
  logic             start;
  logic [1:0]       rows;
  logic [1:0]       cols;
  logic [1:0]       r;
  logic [1:0]       c;
  logic [3:0]       idx;
  logic             at_last_col;
  logic             at_last_row;
  logic [RES_W-1:0] snap [0:8];

  assign start       = unload_res & ~prev;
  assign idx         = 4'(r) * 4'd3 + 4'(c);
  assign at_last_col = (c == cols - 2'd1);
  assign at_last_row = (r == rows - 2'd1);

  // Outputs decode straight from registered state, so they are glitch-free
  // and independent of out_ready.
  assign busy      = (state == STREAM);
  assign out_valid = busy;
  assign out_last  = busy & at_last_col & at_last_row;
  assign out_data  = busy ? snap[idx] : '0;
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev  <= 1'b0;
      rows  <= 2'd0;
      cols  <= 2'd0;
      r     <= 2'd0;
      c     <= 2'd0;
      for (int k = 0; k < 9; k++) snap[k] <= '0;
    end else begin
      // The edge detector keeps tracking even while a stream is in flight,
      // so a level held high across done cannot retrigger.
      prev <= unload_res;
      case (state)
        IDLE: begin
          if (start) begin
            if (row_w != 2'd0 && col_x != 2'd0) begin
              for (int k = 0; k < 9; k++) snap[k] <= mac_res[k*RES_W +: RES_W];
              rows  <= row_w;
              cols  <= col_x;
              r     <= 2'd0;
              c     <= 2'd0;
              state <= STREAM;
            end else begin
              state <= FIN;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (!at_last_col) begin
              c <= c + 2'd1;
            end else if (!at_last_row) begin
              c <= 2'd0;
              r <= r + 2'd1;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_unloader.sv
// Scoreboard bench for mm_result_unloader: expected elements are queued when an
// unload is started and compared against handshakes collected from the DUT.
module tb_mm_result_unloader;

  localparam int RES_W = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               unload_res;
  logic [1:0]         row_w;
  logic [1:0]         col_x;
  logic [9*RES_W-1:0] mac_res;
  logic [RES_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               done;

  mm_result_unloader #(.RES_W(RES_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .unload_res (unload_res),
    .row_w      (row_w),
    .col_x      (col_x),
    .mac_res    (mac_res),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [RES_W-1:0] exp_data [$];
  bit               exp_last [$];
  logic [RES_W-1:0] obs_data [$];
  bit               obs_last [$];
  int               obs_cyc  [$];
  int done_cycle;
  int valid_cycles;
  int busy_err;
  int stall_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mac(input int k, input int v);
    mac_res[k*RES_W +: RES_W] = RES_W'(v);
  endtask

  // Produces a clean rising edge on unload_res and queues the expected stream.
  task automatic start_unload(input int rows, input int cols);
    unload_res = 1'b0;
    tick();
    row_w = rows[1:0];
    col_x = cols[1:0];
    unload_res = 1'b1;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp_data.push_back(mac_res[(3*r+c)*RES_W +: RES_W]);
        exp_last.push_back(r == rows-1 && c == cols-1);
      end
    tick();
  endtask

  // Records handshakes and the cycle of done, counted from 1 = first cycle after
  // the start edge. mode 0: ready always high; mode 1: ready pattern 1,0,0,...
  task automatic collect(input int budget, input int mode);
    logic [RES_W-1:0] held_d;
    bit held_l;
    bit stalled;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    done_cycle = -1;
    valid_cycles = 0;
    busy_err = 0;
    stall_err = 0;
    for (int k = 1; k <= budget; k++) begin
      if (busy !== out_valid) busy_err++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_err++;
        done_cycle = k;
        break;
      end
      if (stalled && (out_data !== held_d || out_last !== held_l)) stall_err++;
      out_ready = (mode == 0) ? 1'b1 : ((k - 1) % 3 == 0);
      if (out_valid === 1'b1) begin
        valid_cycles++;
        if (out_ready) begin
          obs_data.push_back(out_data);
          obs_last.push_back(out_last);
          obs_cyc.push_back(k);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    unload_res = 1'b0;
    out_ready = 1'b0;
    row_w = 2'd0;
    col_x = 2'd0;
    mac_res = '0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", out_last); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%0d want=0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_3x3();
    int i;
    for (int k = 0; k < 9; k++) set_mac(k, 10*k + 1);
    start_unload(3, 3);
    collect(20, 0);
    checks++; if (obs_data.size() !== exp_data.size()) begin failures++; $display("FAIL full_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    i = 1;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL full_data[%0d] got=%0d want=%0d", i, od, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL full_last[%0d] got=%b want=%b", i, ol, el); end
      checks++; if (oc !== i) begin failures++; $display("FAIL full_cycle[%0d] got=%0d want=%0d", i, oc, i); end
      i++;
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (done_cycle !== 10) begin failures++; $display("FAIL full_done_cycle got=%0d want=10", done_cycle); end
    checks++; if (busy_err !== 0) begin failures++; $display("FAIL full_busy got=%0d bad cycles want=0", busy_err); end
  endtask

  task automatic test_partial_2x3();
    for (int k = 0; k < 6; k++) set_mac(k, 3*k + 40);
    for (int k = 6; k < 9; k++) set_mac(k, 'h3FF);
    start_unload(2, 3);
    collect(20, 0);
    checks++; if (obs_data.size() !== 6) begin failures++; $display("FAIL part_count got=%0d want=6", obs_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL part_data got=%0d want=%0d", od, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL part_last got=%b want=%b", ol, el); end
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (done_cycle !== 7) begin failures++; $display("FAIL part_done_cycle got=%0d want=7", done_cycle); end
  endtask

  task automatic test_stall_3x1();
    mac_res = '0;
    set_mac(0, 5); set_mac(3, 7); set_mac(6, 9);
    set_mac(1, 100); set_mac(4, 200); set_mac(7, 300);
    start_unload(3, 1);
    collect(30, 1);
    checks++; if (obs_data.size() !== 3) begin failures++; $display("FAIL stall_count got=%0d want=3", obs_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL stall_data got=%0d want=%0d", od, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL stall_last got=%b want=%b", ol, el); end
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_hold got=%0d changes want=0", stall_err); end
    checks++; if (valid_cycles !== 7) begin failures++; $display("FAIL stall_valid_cycles got=%0d want=7", valid_cycles); end
    checks++; if (done_cycle !== 8) begin failures++; $display("FAIL stall_done_cycle got=%0d want=8", done_cycle); end
  endtask

  task automatic test_snapshot_rearm();
    for (int k = 0; k < 9; k++) set_mac(k, 200 + k);
    start_unload(2, 2);
    mac_res = '0;
    collect(20, 0);
    checks++; if (obs_data.size() !== 4) begin failures++; $display("FAIL snap_count got=%0d want=4", obs_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL snap_data got=%0d want=%0d", od, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL snap_last got=%b want=%b", ol, el); end
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (done_cycle !== 5) begin failures++; $display("FAIL snap_done_cycle got=%0d want=5", done_cycle); end
    // unload_res stays high: the level alone must not start another stream
    tick();
    collect(8, 0);
    checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL held_level_valid got=%0d want=0", valid_cycles); end
    checks++; if (done_cycle !== -1) begin failures++; $display("FAIL held_level_done got=%0d want=-1", done_cycle); end
    for (int k = 0; k < 9; k++) set_mac(k, 300 + k);
    start_unload(2, 2);
    collect(20, 0);
    checks++; if (obs_data.size() !== 4) begin failures++; $display("FAIL rearm_count got=%0d want=4", obs_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL rearm_data got=%0d want=%0d", od, ed); end
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (done_cycle !== 5) begin failures++; $display("FAIL rearm_done_cycle got=%0d want=5", done_cycle); end
  endtask

  task automatic test_empty();
    start_unload(0, 2);
    collect(6, 0);
    checks++; if (done_cycle !== 1) begin failures++; $display("FAIL empty_rows_done got=%0d want=1", done_cycle); end
    checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL empty_rows_valid got=%0d want=0", valid_cycles); end
    start_unload(3, 0);
    collect(6, 0);
    checks++; if (done_cycle !== 1) begin failures++; $display("FAIL empty_cols_done got=%0d want=1", done_cycle); end
    checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL empty_cols_valid got=%0d want=0", valid_cycles); end
    exp_data.delete(); exp_last.delete();
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 9; k++) set_mac(k, 500 + 7*k);
    start_unload(3, 3);
    collect(4, 0);
    checks++; if (obs_data.size() !== 4) begin failures++; $display("FAIL abort_count got=%0d want=4", obs_data.size()); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      logic [RES_W-1:0] ed, od;
      ed = exp_data.pop_front(); void'(exp_last.pop_front());
      od = obs_data.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL abort_data got=%0d want=%0d", od, ed); end
    end
    exp_data.delete(); exp_last.delete();
    // unload_res is still high, so the cycle after reset releases restarts
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
    rst = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_data.push_back(mac_res[(3*r+c)*RES_W +: RES_W]);
        exp_last.push_back(r == 2 && c == 2);
      end
    tick();
    collect(20, 0);
    checks++; if (obs_data.size() !== 9) begin failures++; $display("FAIL restart_count got=%0d want=9", obs_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [RES_W-1:0] ed, od; bit el, ol; int oc;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
      checks++; if (od !== ed) begin failures++; $display("FAIL restart_data got=%0d want=%0d", od, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL restart_last got=%b want=%b", ol, el); end
    end
    exp_data.delete(); exp_last.delete();
    checks++; if (done_cycle !== 10) begin failures++; $display("FAIL restart_done_cycle got=%0d want=10", done_cycle); end
  endtask

  initial begin
    test_reset();
    test_full_3x3();
    test_partial_2x3();
    test_stall_3x1();
    test_snapshot_rearm();
    test_empty();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
